// File: rtl/hat_man3_sprite_fetch_pkg.sv
// Shared types and defaults for the Hat_man3 sprite pixel source.
package hat_man3_pkg;

  localparam int SPR_W_DEFAULT     = 32;
  localparam int SPR_H_DEFAULT     = 48;
  localparam int FRAMES_DEFAULT    = 4;
  localparam int FRAME_DIV_DEFAULT = 8;

  typedef logic [9:0] pix_coord_t;
  typedef logic [3:0] pal_idx_t;

  localparam pal_idx_t TRANSPARENT_IDX = 4'h0;

  function automatic logic is_opaque(input pal_idx_t idx);
    return idx != TRANSPARENT_IDX;
  endfunction

endpackage

// File: rtl/hat_man3_sprite_fetch_if.sv
// Draw-coordinate, game-state and sprite-ROM signals of the Hat_man3 sprite fetch stage.
interface hat_man3_sprite_fetch_if
  import hat_man3_pkg::*;
#(
  parameter int ADDR_W = 13
);

  logic              pix_en;
  logic              vsync_pulse;
  pix_coord_t        DrawX;
  pix_coord_t        DrawY;
  pix_coord_t        pos_x;
  pix_coord_t        pos_y;
  logic              moving;
  logic              facing_left;
  logic [ADDR_W-1:0] rom_addr;
  pal_idx_t          rom_q;
  pal_idx_t          pal_index;
  logic              sprite_hit;

  modport slave (
    input  pix_en, vsync_pulse, DrawX, DrawY, pos_x, pos_y, moving, facing_left, rom_q,
    output rom_addr, pal_index, sprite_hit
  );

  modport master (
    output pix_en, vsync_pulse, DrawX, DrawY, pos_x, pos_y, moving, facing_left, rom_q,
    input  rom_addr, pal_index, sprite_hit
  );

endinterface

// File: rtl/hat_man3_sprite_fetch_anim_ctr.sv
// Walk-cycle divider and frame counter, stepped once per vsync while moving.
module hat_man3_anim_ctr
  import hat_man3_pkg::*;
#(
  parameter int FRAMES    = FRAMES_DEFAULT,
  parameter int FRAME_DIV = FRAME_DIV_DEFAULT,
  parameter int FRAME_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  parameter int DIV_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               i_vsync,
  input  logic               i_moving,
  output logic [FRAME_W-1:0] o_frame
);

  logic [DIV_W-1:0]   r_div;
  logic [FRAME_W-1:0] r_frame;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_div   <= '0;
      r_frame <= '0;
    end else if (i_vsync) begin
      if (!i_moving) begin
        r_div   <= '0;
        r_frame <= '0;
      end else if (r_div == DIV_W'(FRAME_DIV - 1)) begin
        r_div   <= '0;
        r_frame <= (r_frame == FRAME_W'(FRAMES - 1)) ? '0 : r_frame + 1'b1;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_frame = r_frame;

endmodule

// File: rtl/hat_man3_sprite_fetch.sv
// Hat_man3 sprite pixel source: box test, ROM addressing, 2-stage pixel pipeline.
// Build option: HAT_MAN3_MIRROR_EN enables horizontal mirroring via facing_left.
module hat_man3_sprite_fetch
  import hat_man3_pkg::*;
#(
  parameter int SPR_W     = SPR_W_DEFAULT,
  parameter int SPR_H     = SPR_H_DEFAULT,
  parameter int FRAMES    = FRAMES_DEFAULT,
  parameter int FRAME_DIV = FRAME_DIV_DEFAULT,
  parameter int ADDR_W    = $clog2(SPR_W * SPR_H * FRAMES)
) (
  input logic                     Clk,
  input logic                     Reset_n,
  hat_man3_sprite_fetch_if.slave  bus
);

  localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  pix_coord_t         r_px;
  pix_coord_t         r_py;
  logic               r_armed;
  logic [FRAME_W-1:0] w_frame;

  logic               r_inside_p0;
  logic [ADDR_W-1:0]  r_rom_addr_p0;
  logic               r_inside_p1;

  hat_man3_anim_ctr #(
    .FRAMES    (FRAMES),
    .FRAME_DIV (FRAME_DIV),
    .FRAME_W   (FRAME_W)
  ) u_anim (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .i_vsync  (bus.vsync_pulse),
    .i_moving (bus.moving),
    .o_frame  (w_frame)
  );

  // Position is sampled only at frame start so the sprite never tears; r_armed
  // keeps the sprite hidden until that first sample after reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_px    <= '0;
      r_py    <= '0;
      r_armed <= 1'b0;
    end else if (bus.vsync_pulse) begin
      r_px    <= bus.pos_x;
      r_py    <= bus.pos_y;
      r_armed <= 1'b1;
    end
  end

  logic w_mirror;
`ifdef HAT_MAN3_MIRROR_EN
  logic r_face;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)             r_face <= 1'b0;
    else if (bus.vsync_pulse) r_face <= bus.facing_left;
  end
  assign w_mirror = r_face;
`else
  assign w_mirror = 1'b0;
`endif

  // One extra bit on every operand so px+SPR_W cannot wrap past the screen edge.
  logic [10:0] w_dx, w_dy, w_px, w_py, w_col_raw, w_col, w_row;
  logic        w_inside;
  logic [ADDR_W-1:0] w_addr;

  always_comb begin
    w_dx      = {1'b0, bus.DrawX};
    w_dy      = {1'b0, bus.DrawY};
    w_px      = {1'b0, r_px};
    w_py      = {1'b0, r_py};
    w_inside  = r_armed
              && (w_dx >= w_px) && (w_dx < w_px + 11'(SPR_W))
              && (w_dy >= w_py) && (w_dy < w_py + 11'(SPR_H));
    w_col_raw = w_dx - w_px;
    w_row     = w_dy - w_py;
    w_col     = w_mirror ? (11'(SPR_W - 1) - w_col_raw) : w_col_raw;
    w_addr    = ADDR_W'(w_frame) * ADDR_W'(SPR_W * SPR_H)
              + ADDR_W'(w_row) * ADDR_W'(SPR_W)
              + ADDR_W'(w_col);
  end

  // Stage 0: box test and ROM address
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_inside_p0   <= 1'b0;
      r_rom_addr_p0 <= '0;
    end else if (bus.pix_en) begin
      r_inside_p0 <= w_inside;
      if (w_inside) r_rom_addr_p0 <= w_addr;
    end
  end

  // Stage 1: ROM registers its data while the hit flag follows alongside
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)        r_inside_p1 <= 1'b0;
    else if (bus.pix_en) r_inside_p1 <= r_inside_p0;
  end

  logic w_hit;
  assign w_hit          = r_inside_p1 && is_opaque(bus.rom_q);
  assign bus.rom_addr   = r_rom_addr_p0;
  assign bus.sprite_hit = w_hit;
  assign bus.pal_index  = w_hit ? bus.rom_q : TRANSPARENT_IDX;

endmodule

// File: doc/hat_man3_sprite_fetch.md
# hat_man3_sprite_fetch

Upstream pixel-source stage for the Hat_man3 sprite. It maps the VGA controller's current draw coordinate onto the sprite bounding box, addresses the external synchronous sprite ROM (4-bit palette indices), and sequences walk-cycle animation frames. It delivers a registered palette index plus an opaque/hit flag to the Hat_man3 palette lookup and the downstream colour mux. Position, facing and animation change only at frame boundaries, so the sprite never tears mid-frame.

## Interface
Parameters:
- `SPR_W`, 32: sprite width in pixels.
- `SPR_H`, 48: sprite height in pixels.
- `FRAMES`, 4: animation frames stored back-to-back in ROM.
- `FRAME_DIV`, 8: vsync pulses per animation step.
- `ADDR_W`, `$clog2(SPR_W*SPR_H*FRAMES)`: ROM address width.

Ports:
- `Clk`  in  1  system clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `pix_en`  in  1  pixel strobe; the pipeline advances only when high.
- `vsync_pulse`  in  1  one-`Clk` pulse at frame start.
- `DrawX`  in  10  current pixel column.
- `DrawY`  in  10  current pixel row.
- `pos_x`  in  10  sprite top-left x (live value from game logic).
- `pos_y`  in  10  sprite top-left y.
- `moving`  in  1  high: animate.
- `facing_left`  in  1  high: horizontally mirror the sprite.
- `rom_addr`  out  ADDR_W  sprite ROM address.
- `rom_q`  in  4  ROM data, valid one `Clk` after `rom_addr`.
- `pal_index`  out  4  palette index for the palette stage.
- `sprite_hit`  out  1  pixel is inside the box and not transparent.

## Operation
- Latched state, updated on `vsync_pulse` only: `pos_x`, `pos_y`, `facing_left`.
- Animation counter:
  - On `vsync_pulse` with `moving=1`: the divider increments. When it reaches `FRAME_DIV-1`, it clears and `frame` advances, wrapping from `FRAMES-1` to 0.
  - On `vsync_pulse` with `moving=0`: both the divider and `frame` clear to 0.
- `vsync_pulse` acts regardless of `pix_en`.
- Box test uses 11-bit unsigned arithmetic, so there is no wrap: inside = `DrawX >= px` AND `DrawX < px+SPR_W` AND `DrawY >= py` AND `DrawY < py+SPR_H`.
- Offsets: `col = DrawX-px`; `row = DrawY-py`. If mirrored, `col = SPR_W-1-col`.
- Address: `rom_addr = frame*SPR_W*SPR_H + row*SPR_W + col`, truncated to ADDR_W. When outside the box, `rom_addr` holds its previous value.
- Transparency: index 4'h0 (magenta) is transparent. `sprite_hit = inside_d2 AND (rom_q != 0)`.
- `pal_index` = `rom_q` when `sprite_hit=1`, else 4'h0.

## Timing
- Stage 0, first `pix_en` cycle: register `inside`, `rom_addr`.
- Stage 1, next `pix_en` cycle: ROM returns data; register `inside_d2` and the ROM data.
- Latency: `pal_index`/`sprite_hit` correspond to the DrawX/DrawY presented two `pix_en` cycles earlier. The downstream stage delays its coordinates to match.
- With `pix_en=0`, all pipeline registers hold.
- Reset (any time, asynchronous):
  - `rom_addr`, `pal_index`, `sprite_hit`, `frame`, divider, and latched position/facing all go to 0.
  - The first visible sprite appears after the first `vsync_pulse` following reset release.
- `pos_x`/`pos_y` changes mid-frame have no effect until the next `vsync_pulse`.
- Sprite partly off the right/bottom edge: the on-screen part renders and nothing wraps.

## Configuration
- `HAT_MAN3_MIRROR_EN` defined: `facing_left` is latched and mirrors columns.
- Undefined: `facing_left` is ignored, `col` is never mirrored, and the latch register is omitted.

## Structure
- Shared package `hat_man3_pkg` holds:
  - `SPR_W`, `SPR_H`, `FRAMES` defaults;
  - `TRANSPARENT_IDX = 4'h0`;
  - typedef `pix_coord_t` (logic [9:0]);
  - typedef `pal_idx_t` (logic [3:0]).
- One sub-module: `hat_man3_anim_ctr`, the divider plus frame counter driven by `vsync_pulse`/`moving`.

## Test plan
- Reset mid-frame with `sprite_hit=1` → `pal_index=0`, `sprite_hit=0` immediately; the sprite stays absent until the next `vsync_pulse`.
- pos=(100,200) latched; DrawX=100, DrawY=200, `pix_en` held 1; ROM[0]=4'h5 → two cycles later `pal_index=5`, `sprite_hit=1`. DrawX=99 or 132 → `sprite_hit=0`.
- ROM returns 4'h0 inside the box → `sprite_hit=0`, `pal_index=0`.
- `moving=1`, FRAME_DIV=8, 32 vsyncs → `frame` sequence 0,1,2,3, then wraps to 0. Drop `moving` → `frame=0` at the next vsync, and `rom_addr` base returns to 0.
- `HAT_MAN3_MIRROR_EN` defined, `facing_left=1`, pos=(0,0), DrawX=0, DrawY=0 → `rom_addr=31`. Undefined → `rom_addr=0`.
- pos=(620,460); DrawX=639, DrawY=479 → `rom_addr` = row 19, col 19 = 627. No hit ever at DrawX<620 on the same row.
